// File: rtl/demodulador_bpsk_pkg.sv
// Shared definitions for the BPSK echo demodulator: ADC mid-scale, FSM states and a width helper.
package demodulador_bpsk_pkg;

    localparam logic [13:0] CERO_ADC = 14'h1FFF;
    localparam int          ERR_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_WAIT  = 2'd3
    } estado_e;

    function automatic int clog2(input int valor);
        int r;
        r = 0;
        while ((32'd1 << r) < valor) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/demodulador_bpsk_if.sv
// ADC-side inputs and chip/window result outputs of the BPSK demodulator.
interface demodulador_bpsk_if
    import demodulador_bpsk_pkg::*;
#(
    parameter int CHIP_LEN = 64,
    parameter int N_CHIPS  = 16
);
    localparam int CHIP_W = 15 + clog2(CHIP_LEN);
    localparam int CORR_W = CHIP_W + clog2(N_CHIPS);

    logic                     sinc;
    logic [N_CHIPS-1:0]       cod;
    logic [13:0]              adc;
    logic                     bit_dec;
    logic signed [CHIP_W-1:0] chip_sum;
    logic                     bit_valid;
    logic signed [CORR_W-1:0] corr;
    logic [ERR_W-1:0]         err_cnt;
    logic                     corr_valid;
    logic                     busy;

    modport master (
        output sinc, cod, adc,
        input  bit_dec, chip_sum, bit_valid, corr, err_cnt, corr_valid, busy
    );

    modport slave (
        input  sinc, cod, adc,
        output bit_dec, chip_sum, bit_valid, corr, err_cnt, corr_valid, busy
    );

endinterface

// File: rtl/demodulador_bpsk_acumulador_chip.sv
// Sample/chip counters and signed per-chip integrator; flags when a complete chip sum is held.
module acumulador_chip
    import demodulador_bpsk_pkg::*;
#(
    parameter int CHIP_LEN = 64,
    parameter int N_CHIPS  = 16,
    localparam int CHIP_W  = 15 + clog2(CHIP_LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     acc_en,
    input  logic signed [14:0]       muestra,
    output logic                     chip_done,
    output logic                     ultimo_chip,
    output logic                     fin_run,
    output logic signed [CHIP_W-1:0] chip_acc
);
    localparam int POS_W = clog2(CHIP_LEN);
    localparam int CUR_W = clog2(N_CHIPS) + 1;

    logic [POS_W-1:0]         pos_q, pos_d;
    logic [CUR_W-1:0]         cur_q, cur_d;
    logic signed [CHIP_W-1:0] acc_q, acc_d;
    logic                     full_q, full_d;
    logic                     wrap_s;
    logic signed [CHIP_W-1:0] muestra_ext_s;

    // Next-state of counters and integrator; the first sample of a chip replaces the old sum.
    always_comb begin
        wrap_s        = (pos_q == POS_W'(CHIP_LEN - 1));
        muestra_ext_s = {{(CHIP_W-15){muestra[14]}}, muestra};
        pos_d         = pos_q;
        cur_d         = cur_q;
        acc_d         = acc_q;
        full_d        = 1'b0;
        if (clr) begin
            pos_d = '0;
            cur_d = '0;
            acc_d = '0;
        end else if (acc_en) begin
            full_d = wrap_s;
            if (wrap_s) begin
                pos_d = '0;
                cur_d = cur_q + CUR_W'(1);
            end else begin
                pos_d = pos_q + POS_W'(1);
            end
            if (pos_q == '0) begin
                acc_d = muestra_ext_s;
            end else begin
                acc_d = acc_q + muestra_ext_s;
            end
        end else begin
            full_d = 1'b0;
        end
    end

    // Counter and accumulator registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q  <= '0;
            cur_q  <= '0;
            acc_q  <= '0;
            full_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            cur_q  <= cur_d;
            acc_q  <= acc_d;
            full_q <= full_d;
        end
    end

    assign chip_done   = full_q;
    assign chip_acc    = acc_q;
    assign ultimo_chip = (cur_q == CUR_W'(N_CHIPS));
    // The integrator lags the sampled ADC by one edge, so this marks the window's last ADC edge.
    assign fin_run     = (cur_q == CUR_W'(N_CHIPS - 1)) && (pos_q == POS_W'(CHIP_LEN - 2));

endmodule

// File: rtl/demodulador_bpsk.sv
// BPSK receive correlator: integrates ADC echo per code chip, decides bits, and sums the window correlation.
module demodulador_bpsk
    import demodulador_bpsk_pkg::*;
#(
    parameter int CHIP_LEN = 64,
    parameter int N_CHIPS  = 16
) (
    input logic               clk,
    input logic               rst,
    demodulador_bpsk_if.slave bus
);
    localparam int CHIP_W = 15 + clog2(CHIP_LEN);
    localparam int CORR_W = CHIP_W + clog2(N_CHIPS);

    estado_e                  estado_q, estado_d;
    logic                     fl_q, fl_d;
    logic                     sinc_q, sinc_d;
    logic signed [14:0]       s_q, s_d;
    logic                     v_q, v_d;
    logic [N_CHIPS-1:0]       cod_q, cod_d;
    logic signed [CORR_W-1:0] corr_acc_q, corr_acc_d;
    logic [ERR_W-1:0]         err_acc_q, err_acc_d;
    logic                     bit_dec_q, bit_dec_d;
    logic signed [CHIP_W-1:0] chip_sum_q, chip_sum_d;
    logic                     bit_valid_q, bit_valid_d;
    logic signed [CORR_W-1:0] corr_q, corr_d;
    logic [ERR_W-1:0]         err_cnt_q, err_cnt_d;
    logic                     corr_valid_q, corr_valid_d;
    logic                     busy_q, busy_d;

    logic                     rise_s, start_s, abort_s, cierre_s, clr_s;
    logic                     chip_done_s, ultimo_s, fin_run_s;
    logic signed [CHIP_W-1:0] chip_acc_s;
    logic signed [CORR_W-1:0] chip_ext_s, aporte_s, corr_sig_s;
    logic                     dec_s, fallo_s;
    logic [ERR_W-1:0]         err_sig_s;

    assign rise_s   = bus.sinc && !sinc_q;
    assign start_s  = (estado_q == ST_IDLE) && rise_s;
    assign abort_s  = (estado_q == ST_RUN) && !bus.sinc;
    assign cierre_s = chip_done_s && !abort_s;
    assign clr_s    = start_s || abort_s;

    acumulador_chip #(
        .CHIP_LEN (CHIP_LEN),
        .N_CHIPS  (N_CHIPS)
    ) u_acumulador (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr_s),
        .acc_en      (v_q),
        .muestra     (s_q),
        .chip_done   (chip_done_s),
        .ultimo_chip (ultimo_s),
        .fin_run     (fin_run_s),
        .chip_acc    (chip_acc_s)
    );

    // Window FSM: FLUSH lasts two cycles to drain the sample and integrator stages.
    always_comb begin
        estado_d = estado_q;
        fl_d     = 1'b0;
        case (estado_q)
            ST_IDLE: begin
                if (rise_s) estado_d = ST_RUN;
                else        estado_d = ST_IDLE;
            end
            ST_RUN: begin
                if (!bus.sinc)     estado_d = ST_IDLE;
                else if (fin_run_s) estado_d = ST_FLUSH;
                else               estado_d = ST_RUN;
            end
            ST_FLUSH: begin
                if (fl_q) estado_d = bus.sinc ? ST_WAIT : ST_IDLE;
                else      fl_d     = 1'b1;
            end
            ST_WAIT: begin
                if (!bus.sinc) estado_d = ST_IDLE;
                else           estado_d = ST_WAIT;
            end
            default: estado_d = ST_IDLE;
        endcase
        busy_d = (estado_d == ST_RUN) || (estado_d == ST_FLUSH);
    end

    // Sample offset removal, code shift register, correlation/error accumulation and result updates.
    always_comb begin
        sinc_d       = bus.sinc;
        s_d          = $signed({1'b0, bus.adc}) - $signed({1'b0, CERO_ADC});
        v_d          = start_s || ((estado_q == ST_RUN) && bus.sinc);
        dec_s        = ~chip_acc_s[CHIP_W-1];
        fallo_s      = dec_s ^ cod_q[N_CHIPS-1];
        chip_ext_s   = {{(CORR_W-CHIP_W){chip_acc_s[CHIP_W-1]}}, chip_acc_s};
        aporte_s     = cod_q[N_CHIPS-1] ? chip_ext_s : -chip_ext_s;
        corr_sig_s   = corr_acc_q + aporte_s;
        err_sig_s    = err_acc_q + {{(ERR_W-1){1'b0}}, fallo_s};
        cod_d        = cod_q;
        corr_acc_d   = corr_acc_q;
        err_acc_d    = err_acc_q;
        bit_dec_d    = bit_dec_q;
        chip_sum_d   = chip_sum_q;
        bit_valid_d  = 1'b0;
        corr_d       = corr_q;
        err_cnt_d    = err_cnt_q;
        corr_valid_d = 1'b0;
        if (start_s) begin
            cod_d      = bus.cod;
            corr_acc_d = '0;
            err_acc_d  = '0;
        end else if (abort_s) begin
            corr_acc_d = '0;
            err_acc_d  = '0;
        end else if (cierre_s) begin
            cod_d       = {cod_q[N_CHIPS-2:0], 1'b0};
            corr_acc_d  = corr_sig_s;
            err_acc_d   = err_sig_s;
            bit_dec_d   = dec_s;
            chip_sum_d  = chip_acc_s;
            bit_valid_d = 1'b1;
            if (ultimo_s) begin
                corr_d       = corr_sig_s;
                err_cnt_d    = err_sig_s;
                corr_valid_d = 1'b1;
            end else begin
                corr_valid_d = 1'b0;
            end
        end else begin
            bit_valid_d = 1'b0;
        end
    end

    // State, pipeline and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q     <= ST_IDLE;
            fl_q         <= 1'b0;
            sinc_q       <= 1'b0;
            s_q          <= '0;
            v_q          <= 1'b0;
            cod_q        <= '0;
            corr_acc_q   <= '0;
            err_acc_q    <= '0;
            bit_dec_q    <= 1'b0;
            chip_sum_q   <= '0;
            bit_valid_q  <= 1'b0;
            corr_q       <= '0;
            err_cnt_q    <= '0;
            corr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            fl_q         <= fl_d;
            sinc_q       <= sinc_d;
            s_q          <= s_d;
            v_q          <= v_d;
            cod_q        <= cod_d;
            corr_acc_q   <= corr_acc_d;
            err_acc_q    <= err_acc_d;
            bit_dec_q    <= bit_dec_d;
            chip_sum_q   <= chip_sum_d;
            bit_valid_q  <= bit_valid_d;
            corr_q       <= corr_d;
            err_cnt_q    <= err_cnt_d;
            corr_valid_q <= corr_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.bit_dec    = bit_dec_q;
    assign bus.chip_sum   = chip_sum_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.corr       = corr_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.corr_valid = corr_valid_q;
    assign bus.busy       = busy_q;

endmodule
